// File: rtl/spn_crypto_unit.sv
// spn_crypto_unit: 16-bit, 3-round SPN encrypt/decrypt engine with a 32-bit key and a registered result.
module spn_crypto_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  opcode,
  input  logic [15:0] data_in,
  input  logic [31:0] symmetric_secret_key,
  output logic [15:0] data_out,
  output logic [1:0]  valid
);
  // Nibble i of each table is the substitution for input value i.
  localparam logic [63:0] S_TBL  = 64'h7095_C6A3_8BF2_1D4E;
  localparam logic [63:0] SI_TBL = 64'h502B_69D7_FAC1_843E;
  function automatic logic [15:0] sub(input logic [15:0] x, input logic [63:0] t);
    logic [15:0] y;
    for (int i = 0; i < 4; i++) y[4*i +: 4] = t[4*x[4*i +: 4] +: 4];
    return y;
  endfunction
  function automatic logic [15:0] perm(input logic [15:0] x);
    logic [15:0] y;
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) y[4*k+j] = x[4*j+k];
    return y;
  endfunction
  logic [15:0] k0, k1, k2, e1, e2, enc, d1, d2, dec, nxt_data;
  logic [1:0]  nxt_valid;
  assign k0 = symmetric_secret_key[15:0];
  assign k1 = symmetric_secret_key[23:8];
  assign k2 = symmetric_secret_key[31:16];
  assign e1  = perm(sub(data_in ^ k0, S_TBL)) ^ k1;
  assign e2  = perm(sub(e1, S_TBL)) ^ k2;
  assign enc = sub(e2, S_TBL) ^ k0;
  assign d1  = sub(data_in ^ k0, SI_TBL) ^ k2;
  assign d2  = sub(perm(d1), SI_TBL) ^ k1;
  assign dec = sub(perm(d2), SI_TBL) ^ k0;
  // Case default also catches X/Z opcodes, which must report as an error.
  always_comb begin
    nxt_data  = data_out;
    nxt_valid = 2'b00;
    case (opcode)
      2'b00: ;
      2'b01: begin nxt_data = enc; nxt_valid = 2'b01; end
      2'b10: begin nxt_data = dec; nxt_valid = 2'b10; end
      default: begin nxt_data = 16'h0000; nxt_valid = 2'b11; end
    endcase
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      data_out <= 16'h0000;
      valid    <= 2'b00;
    end else begin
      data_out <= nxt_data;
      valid    <= nxt_valid;
    end
endmodule

// File: tb/tb_spn_crypto_unit.sv
// tb_spn_crypto_unit: directed vector table plus reset, back-to-back round-trip and async-reset sequences.
module tb_spn_crypto_unit;
  logic        clk = 0;
  logic        rst = 0;
  logic [1:0]  opcode = 2'b00;
  logic [15:0] data_in = 16'h0000;
  logic [31:0] symmetric_secret_key = 32'h0;
  logic [15:0] data_out;
  logic [1:0]  valid;
  int checks = 0;
  int errors = 0;

  spn_crypto_unit dut (
    .clk(clk), .rst(rst), .opcode(opcode), .data_in(data_in),
    .symmetric_secret_key(symmetric_secret_key), .data_out(data_out), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [15:0] din;
    logic [31:0] key;
    logic [15:0] exp_out;
    logic [1:0]  exp_valid;
  } vec_t;

  logic [3:0] s_m  [16] = '{4'hE,4'h4,4'hD,4'h1,4'h2,4'hF,4'hB,4'h8,4'h3,4'hA,4'h6,4'hC,4'h5,4'h9,4'h0,4'h7};

  function automatic logic [15:0] m_s(input logic [15:0] x);
    return {s_m[x[15:12]], s_m[x[11:8]], s_m[x[7:4]], s_m[x[3:0]]};
  endfunction
  function automatic logic [15:0] m_p(input logic [15:0] x);
    logic [15:0] y = '0;
    for (int b = 0; b < 16; b++) if (x[b]) y[(b%4)*4 + b/4] = 1'b1;
    return y;
  endfunction
  function automatic logic [15:0] m_enc(input logic [15:0] p, input logic [31:0] k);
    logic [15:0] x;
    x = p ^ k[15:0];
    x = m_p(m_s(x)) ^ k[23:8];
    x = m_p(m_s(x)) ^ k[31:16];
    return m_s(x) ^ k[15:0];
  endfunction

  task automatic chk(input string name, input logic [15:0] d, input logic [1:0] v);
    checks++;
    if (data_out !== d || valid !== v) begin
      errors++;
      $display("FAIL %s: got data_out=%h valid=%b, expected data_out=%h valid=%b", name, data_out, valid, d, v);
    end
  endtask

  task automatic drive(input logic [1:0] op, input logic [15:0] din, input logic [31:0] key);
    opcode = op; data_in = din; symmetric_secret_key = key;
  endtask

  vec_t vecs [10];

  initial begin
    vecs[0] = '{2'b01, 16'h0000, 32'h0000_0000, 16'h4770, 2'b01};
    vecs[1] = '{2'b10, 16'h4770, 32'h0000_0000, 16'h0000, 2'b10};
    vecs[2] = '{2'b11, 16'hABCD, 32'h0000_0000, 16'h0000, 2'b11};
    vecs[3] = '{2'b00, 16'h1234, 32'h0000_0000, 16'h0000, 2'b00};
    vecs[4] = '{2'b01, 16'hFFFF, 32'h0000_0000, 16'h3778, 2'b01};
    vecs[5] = '{2'b00, 16'h5555, 32'h0000_0000, 16'h3778, 2'b00};
    vecs[6] = '{2'b10, 16'h3778, 32'h0000_0000, 16'hFFFF, 2'b10};
    vecs[7] = '{2'b01, 16'h0000, 32'h0000_FFFF, 16'h388D, 2'b01};
    vecs[8] = '{2'b10, 16'h388D, 32'h0000_FFFF, 16'h0000, 2'b10};
    vecs[9] = '{2'b11, 16'h9999, 32'hDEAD_BEEF, 16'h0000, 2'b11};

    // Reset held for three cycles, then released with a nop.
    repeat (3) @(negedge clk);
    chk("reset", 16'h0000, 2'b00);
    rst = 1;
    @(negedge clk);
    chk("after_release_nop", 16'h0000, 2'b00);

    foreach (vecs[i]) begin
      drive(vecs[i].op, vecs[i].din, vecs[i].key);
      @(negedge clk);
      chk($sformatf("vec%0d", i), vecs[i].exp_out, vecs[i].exp_valid);
    end

    // Back-to-back encrypt/decrypt with an independent cipher model.
    for (int i = 0; i < 1000; i++) begin
      logic [15:0] p, c;
      logic [31:0] k;
      p = 16'($urandom);
      k = $urandom;
      c = m_enc(p, k);
      drive(2'b01, p, k);
      @(negedge clk);
      chk($sformatf("rnd_enc%0d", i), c, 2'b01);
      drive(2'b10, c, k);
      @(negedge clk);
      chk($sformatf("rnd_dec%0d", i), p, 2'b10);
    end

    // Reset dropped between edges while an encrypt result is on the outputs.
    drive(2'b01, 16'hFFFF, 32'h0);
    @(posedge clk);
    #1 chk("pre_async_rst", 16'h3778, 2'b01);
    #1 rst = 0;
    #1 chk("async_rst", 16'h0000, 2'b00);
    @(negedge clk);
    chk("rst_held", 16'h0000, 2'b00);
    rst = 1;
    drive(2'b01, 16'h0000, 32'h0);
    @(negedge clk);
    chk("enc_after_rst", 16'h4770, 2'b01);
    drive(2'b00, 16'h0000, 32'h0);
    @(negedge clk);
    chk("nop_after_rst", 16'h4770, 2'b00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
